// File: rtl/parity_rr_arbiter.sv
// Round-robin arbiter that shares one parity-check datapath among NUM_REQ FIFOs.
// One beat per cycle is popped from the selected FIFO and registered, with its
// source index, into a single-entry output slot. An owner may keep the slot for
// up to MAX_BURST consecutive beats before ownership rotates.
module parity_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 9,
    parameter int MAX_BURST  = 4,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_grant_o,
    output logic                          out_valid_o,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic [IDW-1:0]                out_id_o,
    input  logic                          out_grant_i,
    output logic                          busy_o
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state_reg;
    logic [IDW-1:0]        rr_ptr_reg;
    logic [IDW-1:0]        owner_reg;
    logic [CW-1:0]         beat_cnt_reg;
    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [IDW-1:0]        out_id_reg;

    logic                  slot_free;
    logic                  keep_owner;
    logic                  do_grant;
    logic                  beat_last;
    logic [IDW-1:0]        scan_start;
    logic                  arb_found;
    logic [IDW-1:0]        arb_idx;
    logic [IDW-1:0]        grant_idx;
    int                    cand;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] data_lane [NUM_REQ];

    // Next index with wrap at NUM_REQ-1 (works for non-power-of-two NUM_REQ).
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) begin
            return '0;
        end
        return idx + IDW'(1);
    endfunction

    // Split the flat data bus into one lane per requester and build grant bits.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign data_lane[gi]   = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_grant_o[gi] = do_grant && (grant_idx == IDW'(gi));
        end
    endgenerate

    // Rotating priority scan: first valid requester at or after scan_start.
    // A releasing owner scans from the index after itself so the hand-off costs no cycle.
    always_comb begin
        scan_start = (state_reg == BURST) ? wrap_inc(owner_reg) : rr_ptr_reg;
        arb_found  = 1'b0;
        arb_idx    = '0;
        cand       = 0;
        // Walk from the farthest offset down so the nearest valid index wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(scan_start) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req_valid_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = IDW'(cand);
            end
        end
    end

    // Grant decision: the current owner wins while it has data, otherwise the scan result.
    // Grants are held off during reset so nothing is popped that would be dropped.
    always_comb begin
        slot_free  = !out_valid_reg || out_grant_i;
        keep_owner = (state_reg == BURST) && req_valid_i[owner_reg];
        do_grant   = !rst && slot_free && (keep_owner || arb_found);
        grant_idx  = keep_owner ? owner_reg : arb_idx;
        sel_data   = data_lane[grant_idx];
        beat_last  = (int'(beat_cnt_reg) + 1 == MAX_BURST);
    end

    // Ownership FSM: tracks owner, burst length and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            owner_reg    <= '0;
            beat_cnt_reg <= '0;
        end else if (do_grant) begin
            if (keep_owner) begin
                if (beat_last) begin
                    state_reg    <= IDLE;
                    rr_ptr_reg   <= wrap_inc(owner_reg);
                    beat_cnt_reg <= '0;
                end else begin
                    beat_cnt_reg <= beat_cnt_reg + CW'(1);
                end
            end else begin
                owner_reg <= arb_idx;
                if (MAX_BURST == 1) begin
                    state_reg    <= IDLE;
                    rr_ptr_reg   <= wrap_inc(arb_idx);
                    beat_cnt_reg <= '0;
                end else begin
                    state_reg    <= BURST;
                    beat_cnt_reg <= CW'(1);
                end
            end
        end else if (state_reg == BURST && slot_free) begin
            // Owner ran dry and nobody else is waiting: give up ownership.
            state_reg    <= IDLE;
            rr_ptr_reg   <= wrap_inc(owner_reg);
            beat_cnt_reg <= '0;
        end
    end

    // Output slot: load on a transfer, drain on checker accept, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_id_reg    <= '0;
        end else if (do_grant) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= sel_data;
            out_id_reg    <= grant_idx;
        end else if (out_grant_i) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_reg;
    assign out_data_o  = out_data_reg;
    assign out_id_o    = out_id_reg;
    assign busy_o      = (state_reg == BURST) || out_valid_reg;

endmodule

// File: tb/tb_parity_rr_arbiter.sv
// Directed testbench for parity_rr_arbiter: one task per scenario, inline checks.
module tb_parity_rr_arbiter;

    logic        clk;
    logic        rst;

    // Instance with default parameters (MAX_BURST=4)
    logic [3:0]  req_valid;
    logic [35:0] req_data;
    logic [3:0]  req_grant;
    logic        out_valid;
    logic [8:0]  out_data;
    logic [1:0]  out_id;
    logic        out_grant;
    logic        busy;

    // Instance with MAX_BURST=1 for the wrap scenario
    logic [3:0]  req_valid1;
    logic [35:0] req_data1;
    logic [3:0]  req_grant1;
    logic        out_valid1;
    logic [8:0]  out_data1;
    logic [1:0]  out_id1;
    logic        out_grant1;
    logic        busy1;

    logic [8:0]  base [4];
    logic [7:0]  head [4];

    int vec_cnt;
    int err_cnt;

    parity_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(9), .MAX_BURST(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_grant_o (req_grant),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_id_o    (out_id),
        .out_grant_i (out_grant),
        .busy_o      (busy)
    );

    parity_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(9), .MAX_BURST(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid1),
        .req_data_i  (req_data1),
        .req_grant_o (req_grant1),
        .out_valid_o (out_valid1),
        .out_data_o  (out_data1),
        .out_id_o    (out_id1),
        .out_grant_i (out_grant1),
        .busy_o      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO head model: each pop advances that FIFO's presented data by one.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 4; r++) head[r] <= 8'd0;
        end else begin
            for (int r = 0; r < 4; r++) begin
                if (req_grant[r] && req_valid[r]) head[r] <= head[r] + 8'd1;
            end
        end
    end

    always_comb begin
        req_data = '0;
        for (int r = 0; r < 4; r++) req_data[r*9 +: 9] = base[r] + 9'(head[r]);
    end

    assign req_data1 = {9'h1F3, 9'h1F2, 9'h1F1, 9'h1F0};

    // Pulse reset for two cycles; returns at a falling edge with reset released.
    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        #1;
        vec_cnt++;
        if ({req_grant, out_valid, out_data, out_id, busy} !== 17'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got grant=%b valid=%b data=%h id=%0d busy=%b, want all 0",
                     req_grant, out_valid, out_data, out_id, busy);
        end
        $display("reset: grant=%b valid=%b busy=%b", req_grant, out_valid, busy);
        rst       = 1'b0;
        req_valid = 4'b0000;
    endtask

    task automatic test_single;
        bit found;
        base[0]   = 9'h101;
        req_valid = 4'b0001;
        out_grant = 1'b1;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            #1;
            vec_cnt++;
            if (req_grant !== 4'b0001) begin
                err_cnt++;
                $display("FAIL single_grant[%0d]: got %b, want 0001", c, req_grant);
            end
            @(posedge clk);
            #1;
            vec_cnt++;
            if ({out_valid, out_id, out_data} !== {1'b1, 2'd0, 9'(9'h101 + c)}) begin
                err_cnt++;
                $display("FAIL single_beat[%0d]: got valid=%b id=%0d data=%h, want 1/0/%h",
                         c, out_valid, out_id, out_data, 9'(9'h101 + c));
            end
            $display("single: beat %0d id=%0d data=%h", c, out_id, out_data);
            @(negedge clk);
        end
        found = 1'b0;
        for (int w = 0; w < 4 && !found; w++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                found = 1'b1;
                vec_cnt++;
                if ({out_id, out_data} !== {2'd0, 9'h105}) begin
                    err_cnt++;
                    $display("FAIL single_fifth: got id=%0d data=%h, want 0/105", out_id, out_data);
                end
                $display("single: beat 4 id=%0d data=%h", out_id, out_data);
            end
        end
        if (!found) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL single_fifth: got no beat within 4 cycles, want data 105");
        end
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    task automatic test_all_valid;
        int n;
        logic [1:0] exp_id;
        logic [8:0] exp_data;
        for (int r = 0; r < 4; r++) base[r] = 9'(r * 32);
        req_valid = 4'b1111;
        out_grant = 1'b1;
        do_reset();
        n = 0;
        for (int c = 0; c < 40 && n < 17; c++) begin
            #1;
            vec_cnt++;
            if (!$onehot0(req_grant)) begin
                err_cnt++;
                $display("FAIL all_onehot[%0d]: got %b, want one-hot or zero", c, req_grant);
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                exp_id   = 2'((n / 4) % 4);
                exp_data = 9'(int'(exp_id) * 32 + ((n < 16) ? (n % 4) : 4));
                vec_cnt++;
                if ({out_id, out_data} !== {exp_id, exp_data}) begin
                    err_cnt++;
                    $display("FAIL all_beat[%0d]: got id=%0d data=%h, want id=%0d data=%h",
                             n, out_id, out_data, exp_id, exp_data);
                end
                $display("all_valid: beat %0d id=%0d data=%h", n, out_id, out_data);
                n++;
            end
            @(negedge clk);
        end
        if (n < 17) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL all_count: got %0d beats in 40 cycles, want 17", n);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_backpressure;
        base[0]   = 9'h0A0;
        req_valid = 4'b0001;
        out_grant = 1'b1;
        do_reset();
        #1;
        @(posedge clk);
        #1;
        vec_cnt++;
        if ({out_valid, out_id, out_data} !== {1'b1, 2'd0, 9'h0A0}) begin
            err_cnt++;
            $display("FAIL bp_first: got valid=%b id=%0d data=%h, want 1/0/0a0", out_valid, out_id, out_data);
        end
        @(negedge clk);
        out_grant = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vec_cnt++;
            if (req_grant !== 4'b0000) begin
                err_cnt++;
                $display("FAIL bp_grant[%0d]: got %b, want 0000", c, req_grant);
            end
            @(posedge clk);
            #1;
            vec_cnt++;
            if ({out_valid, out_id, out_data, busy} !== {1'b1, 2'd0, 9'h0A0, 1'b1}) begin
                err_cnt++;
                $display("FAIL bp_hold[%0d]: got valid=%b id=%0d data=%h busy=%b, want 1/0/0a0/1",
                         c, out_valid, out_id, out_data, busy);
            end
            $display("backpressure: stall %0d data=%h grant=%b", c, out_data, req_grant);
            @(negedge clk);
        end
        out_grant = 1'b1;
        #1;
        vec_cnt++;
        if (req_grant !== 4'b0001) begin
            err_cnt++;
            $display("FAIL bp_reload_grant: got %b, want 0001", req_grant);
        end
        @(posedge clk);
        #1;
        vec_cnt++;
        if ({out_valid, out_id, out_data} !== {1'b1, 2'd0, 9'h0A1}) begin
            err_cnt++;
            $display("FAIL bp_reload_beat: got valid=%b id=%0d data=%h, want 1/0/0a1", out_valid, out_id, out_data);
        end
        $display("backpressure: reload data=%h", out_data);
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    task automatic test_early_release;
        logic [3:0] exp_grant;
        logic [1:0] exp_id;
        for (int r = 0; r < 4; r++) base[r] = 9'(r * 16);
        req_valid = 4'b0100;
        out_grant = 1'b1;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c == 2) req_valid = 4'b1001;
            exp_grant = (c < 2) ? 4'b0100 : 4'b1000;
            exp_id    = (c < 2) ? 2'd2 : 2'd3;
            #1;
            vec_cnt++;
            if (req_grant !== exp_grant) begin
                err_cnt++;
                $display("FAIL early_grant[%0d]: got %b, want %b", c, req_grant, exp_grant);
            end
            @(posedge clk);
            #1;
            vec_cnt++;
            if ({out_valid, out_id} !== {1'b1, exp_id}) begin
                err_cnt++;
                $display("FAIL early_beat[%0d]: got valid=%b id=%0d, want 1/%0d", c, out_valid, out_id, exp_id);
            end
            $display("early_release: cycle %0d grant=%b id=%0d", c, req_grant, out_id);
            @(negedge clk);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_wrap;
        logic [3:0] exp_grant;
        req_valid1 = 4'b0100;
        out_grant1 = 1'b1;
        do_reset();
        #1;
        vec_cnt++;
        if (req_grant1 !== 4'b0100) begin
            err_cnt++;
            $display("FAIL wrap_setup: got %b, want 0100", req_grant1);
        end
        @(negedge clk);
        req_valid1 = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            exp_grant = (c % 2 == 0) ? 4'b1000 : 4'b0001;
            #1;
            vec_cnt++;
            if (req_grant1 !== exp_grant) begin
                err_cnt++;
                $display("FAIL wrap_grant[%0d]: got %b, want %b", c, req_grant1, exp_grant);
            end
            @(posedge clk);
            #1;
            vec_cnt++;
            if ({out_valid1, out_id1} !== {1'b1, (c % 2 == 0) ? 2'd3 : 2'd0}) begin
                err_cnt++;
                $display("FAIL wrap_id[%0d]: got valid=%b id=%0d, want 1/%0d",
                         c, out_valid1, out_id1, (c % 2 == 0) ? 3 : 0);
            end
            $display("wrap: cycle %0d grant=%b id=%0d", c, req_grant1, out_id1);
            @(negedge clk);
        end
        req_valid1 = 4'b0000;
    endtask

    task automatic test_midburst_reset;
        req_valid = 4'b1111;
        out_grant = 1'b0;
        do_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        vec_cnt++;
        if (out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL midrst_pre: got valid=%b, want 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({req_grant, out_valid, out_data, out_id, busy} !== 17'd0) begin
            err_cnt++;
            $display("FAIL midrst_clear: got grant=%b valid=%b data=%h id=%0d busy=%b, want all 0",
                     req_grant, out_valid, out_data, out_id, busy);
        end
        @(negedge clk);
        req_valid = 4'b0110;
        out_grant = 1'b1;
        rst       = 1'b0;
        #1;
        vec_cnt++;
        if (req_grant !== 4'b0010) begin
            err_cnt++;
            $display("FAIL midrst_first: got %b, want 0010", req_grant);
        end
        $display("midburst_reset: first grant after reset=%b", req_grant);
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    initial begin
        vec_cnt    = 0;
        err_cnt    = 0;
        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_valid1 = 4'b0000;
        out_grant  = 1'b1;
        out_grant1 = 1'b1;
        for (int r = 0; r < 4; r++) base[r] = 9'd0;

        test_reset();
        test_single();
        test_all_valid();
        test_backpressure();
        test_early_release();
        test_wrap();
        test_midburst_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
